// File: rtl/onset_pkg.sv
// Shared types and constants for the onset detector: state encoding, sample
// width and the holdoff sizing helpers used by the FSM counters.
package onset_pkg;

    localparam int SAMPLE_W = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        HOLDOFF = 2'd2,
        REARM   = 2'd3
    } onset_state_t;

    function automatic int holdoff_samples(input int sampling_rate, input int holdoff_ms);
        return (sampling_rate * holdoff_ms) / 1000;
    endfunction

    // hold_cnt only has to reach HOLDOFF_SAMPLES-1; keep at least one bit.
    function automatic int hold_cnt_width(input int sampling_rate, input int holdoff_ms);
        int w;
        w = $clog2(holdoff_samples(sampling_rate, holdoff_ms));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/onset_detector_envelope_follower.sv
// Stages 1-2: rectify the limited sample, then attack instantly / decay
// geometrically with a 1 LSB floor so the envelope always reaches zero.
module envelope_follower
    import onset_pkg::*;
#(
    parameter int DECAY_SHIFT = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic [SAMPLE_W-1:0]        envelope,
    output logic                       env_valid,
    output logic                       rose
);
    logic [SAMPLE_W-1:0] sample_u;
    logic [SAMPLE_W-1:0] abs_val;
    logic [SAMPLE_W-1:0] mag_q;
    logic                mag_valid_q;
    logic [SAMPLE_W-1:0] env_q;
    logic [SAMPLE_W-1:0] decay;
    logic                env_valid_q;
    logic                rose_q;

    // -2048 negates to 0x800, which reads correctly as unsigned 2048.
    assign sample_u = unsigned'(sample);
    assign abs_val  = sample_u[SAMPLE_W-1] ? (~sample_u + 1'b1) : sample_u;
    assign decay    = env_q >> DECAY_SHIFT;

    always_ff @(posedge clock) begin
        if (reset) begin
            mag_q       <= '0;
            mag_valid_q <= 1'b0;
        end else begin
            mag_valid_q <= sample_valid;
            if (sample_valid) begin
                mag_q <= abs_val;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            env_q       <= '0;
            env_valid_q <= 1'b0;
            rose_q      <= 1'b0;
        end else begin
            env_valid_q <= mag_valid_q;
            if (mag_valid_q) begin
                rose_q <= (mag_q >= env_q);
                if (mag_q >= env_q) begin
                    env_q <= mag_q;
                end else if (decay != '0) begin
                    env_q <= env_q - decay;
                end else if (env_q != '0) begin
                    env_q <= env_q - 1'b1;
                end
            end
        end
    end

    assign envelope  = env_q;
    assign env_valid = env_valid_q;
    assign rose      = rose_q;

endmodule

// File: rtl/onset_detector.sv
// Drum onset detector: envelope follower feeding a hysteresis FSM that emits
// one hit pulse with peak velocity per physical hit, then holds off.
module onset_detector
    import onset_pkg::*;
#(
    parameter int SAMPLING_RATE = 24000,
    parameter int HOLDOFF_MS    = 50,
    parameter int DECAY_SHIFT   = 4,
    parameter int MAX_ATTACK    = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0]        threshold_on,
    input  logic [SAMPLE_W-1:0]        threshold_off,
    output logic [SAMPLE_W-1:0]        envelope,
    output logic                       hit,
    output logic [SAMPLE_W-1:0]        velocity,
    output logic [1:0]                 state_dbg
);
    localparam int HOLD_N = holdoff_samples(SAMPLING_RATE, HOLDOFF_MS);
    localparam int HOLD_W = hold_cnt_width(SAMPLING_RATE, HOLDOFF_MS);
    localparam int ATK_W  = $clog2(MAX_ATTACK + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_N - 1);
    localparam logic [ATK_W-1:0]  ATK_MAX   = ATK_W'(MAX_ATTACK);

    // sample_valid has no ready: the detector accepts a sample on every cycle
    // it is high, so the upstream limiter can never be stalled.
    logic [SAMPLE_W-1:0] env;
    logic                env_valid;
    logic                rose;

    envelope_follower #(
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_envelope_follower (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .envelope     (env),
        .env_valid    (env_valid),
        .rose         (rose)
    );

    onset_state_t        state_q, state_d;
    logic [SAMPLE_W-1:0] peak_q, peak_d;
    logic [SAMPLE_W-1:0] velocity_q, velocity_d;
    logic [ATK_W-1:0]    attack_cnt_q, attack_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                hit_q, hit_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            peak_q       <= '0;
            velocity_q   <= '0;
            attack_cnt_q <= '0;
            hold_cnt_q   <= '0;
            hit_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            peak_q       <= peak_d;
            velocity_q   <= velocity_d;
            attack_cnt_q <= attack_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            hit_q        <= hit_d;
        end
    end

    // Steps only on an envelope update; between updates everything holds.
    always_comb begin
        state_d      = state_q;
        peak_d       = peak_q;
        velocity_d   = velocity_q;
        attack_cnt_d = attack_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        hit_d        = 1'b0;
        if (env_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (env >= threshold_on) begin
                        state_d      = ATTACK;
                        peak_d       = env;
                        attack_cnt_d = ATK_W'(1);
                    end
                end
                ATTACK: begin
                    if (rose && (attack_cnt_q < ATK_MAX)) begin
                        peak_d       = env;
                        attack_cnt_d = attack_cnt_q + 1'b1;
                    end else begin
                        // A still-rising update here is the forced hit; its
                        // envelope is the peak so far.
                        hit_d      = 1'b1;
                        velocity_d = rose ? env : peak_q;
                        state_d    = HOLDOFF;
                        hold_cnt_d = '0;
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = REARM;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                REARM: begin
                    if (env < threshold_off) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign envelope  = env;
    assign hit       = hit_q;
    assign velocity  = velocity_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_onset_detector.sv
// Self-checking bench for onset_detector: directed scenarios plus randomized
// streams compared against a sample-level reference model.
module tb_onset_detector;

    logic        clock = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [11:0] sample;
    logic [11:0] threshold_on;
    logic [11:0] threshold_off;
    logic [11:0] envelope;
    logic        hit;
    logic [11:0] velocity;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    onset_detector dut (
        .clock         (clock),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .sample        (sample),
        .threshold_on  (threshold_on),
        .threshold_off (threshold_off),
        .envelope      (envelope),
        .hit           (hit),
        .velocity      (velocity),
        .state_dbg     (state_dbg)
    );

    // Reference model: processes a whole sample at once; states are
    // 0 idle, 1 attack, 2 holdoff, 3 rearm.
    int m_env, m_state, m_peak, m_vel, m_attack_updates, m_hold_updates;
    int env_h1, hit_h1, vel_h1, st_h1, hit_h2, vel_h2, st_h2;
    logic [11:0] exp_env, exp_vel;
    logic        exp_hit;
    logic [1:0]  exp_state;

    function automatic void model_clear();
        m_env = 0; m_state = 0; m_peak = 0; m_vel = 0;
        m_attack_updates = 0; m_hold_updates = 0;
        env_h1 = 0; hit_h1 = 0; vel_h1 = 0; st_h1 = 0;
        hit_h2 = 0; vel_h2 = 0; st_h2 = 0;
        exp_env = '0; exp_vel = '0; exp_hit = 1'b0; exp_state = '0;
    endfunction

    function automatic int model_sample(input int s);
        int  mag;
        bit  rose;
        int  hit_now;
        mag     = (s < 0) ? -s : s;
        rose    = (mag >= m_env);
        hit_now = 0;
        if (rose)              m_env = mag;
        else if (m_env/16 > 0) m_env = m_env - m_env/16;
        else if (m_env > 0)    m_env = m_env - 1;
        case (m_state)
            0: if (m_env >= int'(threshold_on)) begin
                m_state = 1; m_peak = m_env; m_attack_updates = 0;
            end
            1: begin
                m_attack_updates++;
                if (!rose || m_attack_updates == 64) begin
                    hit_now = 1;
                    m_vel   = rose ? m_env : m_peak;
                    m_state = 2;
                    m_hold_updates = 0;
                end else begin
                    m_peak = m_env;
                end
            end
            2: begin
                m_hold_updates++;
                if (m_hold_updates == 1200) m_state = 3;
            end
            default: if (m_env < int'(threshold_off)) m_state = 0;
        endcase
        return hit_now;
    endfunction

    // One clock: drive at the falling edge, advance the model at the rising
    // edge, return at the next falling edge where DUT outputs are stable.
    task automatic step(input logic v, input logic [11:0] s);
        sample_valid = v;
        sample       = s;
        @(posedge clock);
        if (reset) begin
            model_clear();
        end else begin
            exp_env   = 12'(env_h1);
            exp_hit   = 1'(hit_h2);
            exp_vel   = 12'(vel_h2);
            exp_state = 2'(st_h2);
            hit_h2 = hit_h1; vel_h2 = vel_h1; st_h2 = st_h1;
            hit_h1 = v ? model_sample(int'($signed(s))) : 0;
            env_h1 = m_env; vel_h1 = m_vel; st_h1 = m_state;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 12'd0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            threshold_on  = 12'($urandom);
            threshold_off = 12'($urandom);
            step(1'($urandom_range(0, 1)), 12'($urandom));
            checks++;
            if (envelope !== 12'd0 || hit !== 1'b0 || velocity !== 12'd0 || state_dbg !== 2'd0) begin
                failures++;
                $display("FAIL reset: env=%0d hit=%0d vel=%0d state=%0d, expected all 0",
                         envelope, hit, velocity, state_dbg);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_impulse();
        threshold_on = 12'd512; threshold_off = 12'd256;
        do_reset();
        step(1'b1, 12'd0); step(1'b1, 12'd1000); step(1'b0, 12'd0); step(1'b0, 12'd0);
        checks++;
        if (state_dbg !== 2'd1) begin
            failures++; $display("FAIL impulse_attack: state=%0d expected 1", state_dbg);
        end
        step(1'b1, 12'd1500); step(1'b1, 12'd300); step(1'b0, 12'd0);
        checks++;
        if (hit !== 1'b0 || envelope !== 12'd1407) begin
            failures++; $display("FAIL impulse_env: hit=%0d env=%0d expected hit 0 env 1407", hit, envelope);
        end
        step(1'b0, 12'd0);
        checks++;
        if (hit !== 1'b1 || velocity !== 12'd1500 || state_dbg !== 2'd2) begin
            failures++; $display("FAIL impulse_hit: hit=%0d vel=%0d state=%0d expected 1/1500/2", hit, velocity, state_dbg);
        end
        step(1'b0, 12'd0);
        checks++;
        if (hit !== 1'b0 || velocity !== 12'd1500 || envelope !== 12'd1407) begin
            failures++; $display("FAIL impulse_width: hit=%0d vel=%0d env=%0d expected 0/1500/1407", hit, velocity, envelope);
        end
    endtask

    task automatic test_negative_full_scale();
        threshold_on = 12'd512; threshold_off = 12'd256;
        do_reset();
        step(1'b1, 12'h800); step(1'b0, 12'd0);
        checks++;
        if (envelope !== 12'd2048) begin
            failures++; $display("FAIL negfs_env: env=%0d expected 2048", envelope);
        end
        step(1'b1, 12'd0); step(1'b0, 12'd0); step(1'b0, 12'd0);
        checks++;
        if (hit !== 1'b1 || velocity !== 12'd2048 || envelope !== 12'd1920) begin
            failures++; $display("FAIL negfs_hit: hit=%0d vel=%0d env=%0d expected 1/2048/1920", hit, velocity, envelope);
        end
    endtask

    task automatic test_holdoff();
        int hits_in_window;
        threshold_on = 12'd512; threshold_off = 12'd256;
        do_reset();
        step(1'b1, 12'd1000); step(1'b1, 12'd1500); step(1'b1, 12'd300);
        step(1'b0, 12'd0); step(1'b0, 12'd0);
        checks++;
        if (hit !== 1'b1 || velocity !== 12'd1500) begin
            failures++; $display("FAIL holdoff_first_hit: hit=%0d vel=%0d expected 1/1500", hit, velocity);
        end
        hits_in_window = 0;
        for (int i = 1; i <= 1199; i++) begin
            step(1'b1, (i == 501) ? 12'd1500 : 12'd0);
            if (hit === 1'b1) hits_in_window++;
        end
        step(1'b0, 12'd0); if (hit === 1'b1) hits_in_window++;
        step(1'b0, 12'd0); if (hit === 1'b1) hits_in_window++;
        checks++;
        if (hits_in_window != 0 || state_dbg !== 2'd2) begin
            failures++; $display("FAIL holdoff_ignore: hits=%0d state=%0d expected 0 hits state 2", hits_in_window, state_dbg);
        end
        step(1'b1, 12'd0); step(1'b0, 12'd0); step(1'b0, 12'd0);
        checks++;
        if (state_dbg !== 2'd3) begin
            failures++; $display("FAIL holdoff_to_rearm: state=%0d expected 3", state_dbg);
        end
        step(1'b1, 12'd0); step(1'b0, 12'd0); step(1'b0, 12'd0);
        checks++;
        if (state_dbg !== 2'd0 || envelope !== exp_env) begin
            failures++; $display("FAIL rearm_to_idle: state=%0d env=%0d expected 0 env %0d", state_dbg, envelope, exp_env);
        end
        step(1'b1, 12'd1000); step(1'b1, 12'd1500); step(1'b1, 12'd300);
        step(1'b0, 12'd0); step(1'b0, 12'd0);
        checks++;
        if (hit !== 1'b1 || velocity !== 12'd1500) begin
            failures++; $display("FAIL holdoff_second_hit: hit=%0d vel=%0d expected 1/1500", hit, velocity);
        end
    endtask

    task automatic test_decay_floor();
        int want;
        threshold_on = 12'd512; threshold_off = 12'd256;
        do_reset();
        step(1'b1, 12'd10); step(1'b0, 12'd0);
        checks++;
        if (envelope !== 12'd10) begin
            failures++; $display("FAIL decay_start: env=%0d expected 10", envelope);
        end
        for (int i = 1; i <= 13; i++) begin
            step(1'b1, 12'd0); step(1'b0, 12'd0);
            want = (i < 10) ? 10 - i : 0;
            checks++;
            if (envelope !== 12'(want)) begin
                failures++; $display("FAIL decay_step%0d: env=%0d expected %0d", i, envelope, want);
            end
        end
    endtask

    task automatic test_reset_in_attack();
        int hits_seen;
        threshold_on = 12'd512; threshold_off = 12'd256;
        do_reset();
        step(1'b1, 12'd1000); step(1'b0, 12'd0); step(1'b0, 12'd0);
        checks++;
        if (state_dbg !== 2'd1) begin
            failures++; $display("FAIL abort_attack_entry: state=%0d expected 1", state_dbg);
        end
        reset = 1'b1;
        step(1'b1, 12'd300);
        reset = 1'b0;
        hits_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 12'd0);
            if (hit === 1'b1) hits_seen++;
        end
        checks++;
        if (hits_seen != 0 || state_dbg !== 2'd0) begin
            failures++; $display("FAIL abort_attack: hits=%0d state=%0d expected 0 hits state 0", hits_seen, state_dbg);
        end
    endtask

    task automatic test_max_attack();
        int hits_seen;
        int hit_at;
        logic [11:0] vel_seen;
        threshold_on = 12'd512; threshold_off = 12'd256;
        do_reset();
        hits_seen = 0; hit_at = -1; vel_seen = '0;
        for (int i = 0; i < 74; i++) begin
            if (i < 70) step(1'b1, 12'(600 + 20 * i));
            else        step(1'b0, 12'd0);
            if (hit === 1'b1) begin
                hits_seen++; hit_at = i; vel_seen = velocity;
            end
        end
        checks++;
        if (hits_seen != 1 || hit_at != 66 || vel_seen !== 12'd1880) begin
            failures++;
            $display("FAIL max_attack: hits=%0d at=%0d vel=%0d expected 1 hit at 66 vel 1880",
                     hits_seen, hit_at, vel_seen);
        end
    endtask

    task automatic test_random();
        int   r;
        logic v;
        logic [11:0] s;
        logic prev_hit;
        for (int round = 0; round < 3; round++) begin
            case (round)
                0:       begin threshold_on = 12'd0;   threshold_off = 12'd300; end
                1:       begin threshold_on = 12'($urandom_range(200, 1500));
                               threshold_off = 12'($urandom_range(0, 1800)); end
                default: begin threshold_on = 12'd700; threshold_off = 12'd0; end
            endcase
            do_reset();
            prev_hit = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                v = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 9) == 0) begin
                    s = 12'($urandom);
                end else begin
                    r = int'($urandom_range(0, 199)) - 100;
                    s = 12'(r);
                end
                step(v, s);
                checks++;
                if (envelope !== exp_env || hit !== exp_hit || velocity !== exp_vel || state_dbg !== exp_state) begin
                    failures++;
                    $display("FAIL random r%0d c%0d: env=%0d hit=%0d vel=%0d state=%0d expected %0d/%0d/%0d/%0d",
                             round, c, envelope, hit, velocity, state_dbg, exp_env, exp_hit, exp_vel, exp_state);
                end
                checks++;
                if (hit === 1'b1 && prev_hit === 1'b1) begin
                    failures++; $display("FAIL hit_width r%0d c%0d: hit=1 twice, expected single cycle", round, c);
                end
                prev_hit = hit;
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        sample_valid  = 1'b0;
        sample        = '0;
        threshold_on  = '0;
        threshold_off = '0;
        model_clear();
        @(negedge clock);
        test_reset();
        test_impulse();
        test_negative_full_scale();
        test_holdoff();
        test_decay_floor();
        test_reset_in_attack();
        test_max_attack();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/onset_detector.md
Name: onset_detector

Overview:
- Downstream consumer of the limiter stage. Takes each limited signed 12-bit sample and its completion strobe, and tracks an amplitude envelope.
- Detects drum-hit onsets using a hysteresis threshold pair.
- Emits a one-cycle hit pulse with a peak-amplitude "velocity" for the trigger/sound-select logic.
- Applies a refractory holdoff so one physical hit produces exactly one event.

Parameters:
- SAMPLING_RATE, 24000: sample rate in Hz.
- HOLDOFF_MS, 50: refractory time in ms. HOLDOFF_SAMPLES = SAMPLING_RATE*HOLDOFF_MS/1000, which is 1200 at the defaults.
- DECAY_SHIFT, 4: envelope decay per sample is env>>DECAY_SHIFT.
- MAX_ATTACK, 64: maximum samples spent in ATTACK before a hit is forced.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- sample_valid  in  1  one-cycle strobe (the limiter's done); may be high on consecutive cycles
- sample  in  12  signed limited sample, sampled when sample_valid=1
- threshold_on  in  12  unsigned envelope level that arms an onset
- threshold_off  in  12  unsigned envelope level below which the detector re-arms
- envelope  out  12  unsigned current envelope
- hit  out  1  one-cycle onset pulse
- velocity  out  12  unsigned peak envelope of the onset; valid when hit=1, held until the next hit
- state_dbg  out  2  current FSM state encoding

Behaviour:
- Reset: envelope=0, hit=0, velocity=0, state=IDLE, all internal valids, counters and peak cleared. Reset mid-operation aborts any ATTACK with no hit emitted.
- Stage 1 (cycle N+1 after sample_valid at N): mag <= |sample|.
  - -2048 maps to 2048 (0x800); 12-bit unsigned, no saturation needed.
- Stage 2 (N+2): envelope update.
  - if mag >= env then env <= mag;
  - else if (env>>DECAY_SHIFT) != 0 then env <= env - (env>>DECAY_SHIFT);
  - else if env != 0 then env <= env-1;
  - else env stays 0.
  - Envelope never underflows and never stalls above 0.
- Stage 3 (N+3): the FSM steps once per envelope update. The FSM and counters hold when no update occurs.
  - Hit latency: 3 cycles after the sample_valid of the deciding sample.
  - Full throughput: one sample per cycle.
- IDLE:
  - if env >= threshold_on, go to ATTACK; peak <= env, attack_cnt <= 1.
- ATTACK:
  - if the envelope rose (mag >= previous env), peak <= env and attack_cnt++.
  - otherwise (first decaying update) assert hit, velocity <= peak, go to HOLDOFF, hold_cnt <= 0.
  - if attack_cnt reaches MAX_ATTACK, force the same hit/transition with the current peak.
- HOLDOFF:
  - hold_cnt++ per update; new onsets are ignored.
  - when hold_cnt = HOLDOFF_SAMPLES-1, go to REARM.
- REARM:
  - if env < threshold_off, go to IDLE; otherwise stay.
  - No hits are possible outside ATTACK→HOLDOFF.
- Boundary cases:
  - threshold_on=0: every update in IDLE enters ATTACK. Legal.
  - threshold_off > threshold_on: legal. REARM exits on env < threshold_off only.
  - threshold_off=0: REARM never exits, since env < 0 is impossible. Documented and legal.
  - Thresholds are sampled combinationally each FSM step; changes take effect on the next update.
- hit is exactly one cycle wide. It is never asserted on consecutive cycles.

Decomposition:
- Shared package onset_pkg:
  - 2-bit state encodings IDLE=0, ATTACK=1, HOLDOFF=2, REARM=3;
  - SAMPLE_W=12;
  - a constant function computing HOLDOFF_SAMPLES and the hold_cnt width (clog2).
- One sub-module, envelope_follower, containing stages 1–2 (abs plus decay) with a valid-out strobe and a rose flag. onset_detector instantiates it and holds the FSM, counters and outputs.

Test Plan:
- Reset with random inputs active → envelope=0, hit=0, velocity=0, state_dbg=0 on the cycle after reset.
- Impulse test, thresholds on=512, off=256, shift 4:
  - stimulus: samples 0, 1000, 1500, then 300;
  - required: ATTACK entered after 1000; hit one cycle wide 3 cycles after the 300 strobe; velocity=1500; envelope then reads 1407.
- Negative full scale:
  - stimulus: sample -2048, then 0;
  - required: envelope=2048; hit with velocity=2048.
- Holdoff:
  - stimulus: second 1500 impulse 500 samples after a hit;
  - required: no hit, state stays HOLDOFF; after 1200 samples and env < 256, state returns to IDLE; a new impulse produces a hit.
- Decay floor:
  - stimulus: envelope 10, then zero samples;
  - required: envelope 9, 8, …, 0 one step per strobe, then holds at 0.
- Reset asserted in ATTACK (after the 1000 sample) → no hit ever emitted for that onset; state_dbg=0.
- MAX_ATTACK:
  - stimulus: monotonically rising ramp of 70 samples above threshold;
  - required: forced hit after the 64th ATTACK update, velocity equal to the envelope at that update.
